weight_csr_encoder: RTL

//  Compresses one dense weight slice (R_LEN rows x K_LEN channels, single filter column s) into
//  CSR form: nonzero values, per-entry row r and channel k, and cumulative row pointers ptr[].

---
 rtl/weight_csr_encoder_pkg.sv | 26 ++
 rtl/weight_csr_encoder_if.sv | 26 ++
 rtl/weight_csr_encoder_entry_store.sv | 32 +++
 rtl/weight_csr_encoder.sv | 139 +++++++++++++
 4 files changed

// File: rtl/weight_csr_encoder_pkg.sv
// Shared types and default geometry for the weight CSR encoder
// and the RF address generator that consumes its output.
package weight_csr_pkg;

   localparam int DEF_R_LEN   = 3;
   localparam int DEF_K_LEN   = 4;
   localparam int DEF_VAL_W   = 8;
   localparam int DEF_MAX_NNZ = DEF_R_LEN * DEF_K_LEN;

   localparam int DEF_R_W = $clog2(DEF_R_LEN) + 1;
   localparam int DEF_K_W = $clog2(DEF_K_LEN) + 1;
   localparam int DEF_N_W = $clog2(DEF_MAX_NNZ) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [DEF_VAL_W-1:0] val;
      logic [DEF_R_W-1:0]   r;
      logic [DEF_K_W-1:0]   k;
   } entry_t;

endpackage

// File: rtl/weight_csr_encoder_if.sv
// Dense weight stream handshake between the weight loader
// and the CSR encoder.
interface weight_csr_encoder_if #(
   parameter int VAL_W = 8
);

   logic             start;
   logic             valid;
   logic             ready;
   logic [VAL_W-1:0] data;

   modport master (
      output start,
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  start,
      input  valid,
      input  data,
      output ready
   );

endinterface

// File: rtl/weight_csr_encoder_entry_store.sv
// CSR entry register file: one write port, all entries
// visible in parallel.
module csr_entry_store
   import weight_csr_pkg::*;
#(
   parameter int  DEPTH = DEF_MAX_NNZ,
   parameter int  AW    = DEF_N_W,
   parameter type T     = entry_t
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  T              i_wdata,
   output T              o_q [DEPTH]
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            o_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_we && i_waddr == AW'(i)) begin
               o_q[i] <= i_wdata;
            end
         end
      end
   end

endmodule

// File: rtl/weight_csr_encoder.sv
// Dense-to-CSR encoder for one R_LEN x K_LEN weight slice:
// values, r/k per entry, cumulative row pointers and length.
module weight_csr_encoder #(
   parameter int R_LEN   = weight_csr_pkg::DEF_R_LEN,
   parameter int K_LEN   = weight_csr_pkg::DEF_K_LEN,
   parameter int VAL_W   = weight_csr_pkg::DEF_VAL_W,
   parameter int MAX_NNZ = R_LEN * K_LEN
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   weight_csr_encoder_if.slave          bus,
   output logic [VAL_W-1:0]             o_val [MAX_NNZ],
   output logic [$clog2(R_LEN):0]       o_r   [MAX_NNZ],
   output logic [$clog2(K_LEN):0]       o_k   [MAX_NNZ],
   output logic [$clog2(MAX_NNZ):0]     o_ptr [R_LEN+1],
   output logic [$clog2(MAX_NNZ):0]     o_length,
   output logic                         o_overflow,
   output logic                         o_busy,
   output logic                         o_finish
);

   import weight_csr_pkg::*;

   localparam int R_W = $clog2(R_LEN) + 1;
   localparam int K_W = $clog2(K_LEN) + 1;
   localparam int N_W = $clog2(MAX_NNZ) + 1;

   typedef struct packed {
      logic [VAL_W-1:0] val;
      logic [R_W-1:0]   r;
      logic [K_W-1:0]   k;
   } ent_t;

   state_t           state;
   state_t           nxt;
   logic [R_W-1:0]   row_q;
   logic [K_W-1:0]   chan_q;
   logic             go;
   logic             accept;
   logic             nz;
   logic             wr;
   logic             last_k;
   logic             last;
   logic [N_W-1:0]   len_nxt;
   ent_t             wdata;
   ent_t             ents [MAX_NNZ];

   assign bus.ready = (state == S_SCAN);
   assign go        = (state == S_IDLE) && bus.start;
   assign accept    = bus.valid && bus.ready;
   assign nz        = (bus.data != '0);
   assign wr        = accept && nz && (o_length < N_W'(MAX_NNZ));
   assign len_nxt   = o_length + N_W'(wr);
   assign last_k    = (chan_q == K_W'(K_LEN - 1));
   assign last      = accept && last_k && (row_q == R_W'(R_LEN - 1));
   assign wdata     = '{val: bus.data, r: row_q, k: chan_q};
   assign o_busy    = (state != S_IDLE);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt      = state;
      o_finish = 1'b0;
      unique case (state)
         S_IDLE: if (bus.start) nxt = S_SCAN;
         S_SCAN: if (last) nxt = S_DONE;
         S_DONE: begin
            nxt      = S_IDLE;
            o_finish = 1'b1;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Row pointers latch the post-update length on the last channel of a row.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         row_q      <= '0;
         chan_q     <= '0;
         o_length   <= '0;
         o_overflow <= 1'b0;
         for (int i = 0; i <= R_LEN; i++) begin
            o_ptr[i] <= '0;
         end
      end else if (go) begin
         row_q      <= '0;
         chan_q     <= '0;
         o_length   <= '0;
         o_overflow <= 1'b0;
         for (int i = 0; i <= R_LEN; i++) begin
            o_ptr[i] <= '0;
         end
      end else if (accept) begin
         o_length <= len_nxt;
         if (nz && !wr) begin
            o_overflow <= 1'b1;
         end
         if (last_k) begin
            chan_q <= '0;
            row_q  <= row_q + 1'b1;
            for (int i = 1; i <= R_LEN; i++) begin
               if (row_q == R_W'(i - 1)) begin
                  o_ptr[i] <= len_nxt;
               end
            end
         end else begin
            chan_q <= chan_q + 1'b1;
         end
      end
   end

   csr_entry_store #(
      .DEPTH (MAX_NNZ),
      .AW    (N_W),
      .T     (ent_t)
   ) u_store (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (wr),
      .i_waddr (o_length),
      .i_wdata (wdata),
      .o_q     (ents)
   );

   always_comb begin
      for (int i = 0; i < MAX_NNZ; i++) begin
         o_val[i] = ents[i].val;
         o_r[i]   = ents[i].r;
         o_k[i]   = ents[i].k;
      end
   end

endmodule
